multicycle_control_fsm: RTL and testbench

- Moore/Mealy main controller for the multi-cycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback over shared ALU, register file and single unified memory port.
- Drives the 3-bit ALUOp consumed by the ALU control decoder.
- Handles memory wait states through a ready handshake and flags illegal opcodes.

---
 rtl/multicycle_control_fsm.sv | 218 +++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Main controller for the multi-cycle MIPS datapath: fetch/decode/execute/memory/writeback sequencing.
// Optional performance counters are built when CTRL_PERF_CNT_EN is defined.
module multicycle_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             regs_equal,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             illegal,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [3:0] FETCH     = 4'd0;
    localparam logic [3:0] DECODE    = 4'd1;
    localparam logic [3:0] EXEC_R    = 4'd2;
    localparam logic [3:0] EXEC_I    = 4'd3;
    localparam logic [3:0] MEM_ADDR  = 4'd4;
    localparam logic [3:0] MEM_READ  = 4'd5;
    localparam logic [3:0] MEM_WRITE = 4'd6;
    localparam logic [3:0] WB_ALU    = 4'd7;
    localparam logic [3:0] WB_I      = 4'd8;
    localparam logic [3:0] WB_MEM    = 4'd9;
    localparam logic [3:0] BRANCH    = 4'd10;
    localparam logic [3:0] JUMP      = 4'd11;
    localparam logic [3:0] JR        = 4'd12;
    localparam logic [3:0] HALT      = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    logic [3:0] state;
    logic [3:0] next_state;
    logic       illegal_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == HALT)
                illegal_q <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH:     if (mem_ready) next_state = DECODE;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:               next_state = (funct == FN_JR) ? JR : EXEC_R;
                    OP_ADDI, OP_ORI, OP_ANDI: next_state = EXEC_I;
                    OP_LW, OP_SW:           next_state = MEM_ADDR;
                    OP_BEQ, OP_BNE:         next_state = BRANCH;
                    OP_J, OP_JAL:           next_state = JUMP;
                    default:                next_state = HALT;
                endcase
            end
            EXEC_R:    next_state = WB_ALU;
            EXEC_I:    next_state = WB_I;
            MEM_ADDR:  next_state = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
            MEM_READ:  if (mem_ready) next_state = WB_MEM;
            MEM_WRITE: if (mem_ready) next_state = FETCH;
            WB_ALU, WB_I, WB_MEM, BRANCH, JUMP, JR: next_state = FETCH;
            HALT:      next_state = HALT;
            default:   next_state = FETCH;
        endcase
    end

    // Everything is held at zero while reset is low so an aborted instruction writes nothing.
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 3'b000;
        if (reset) begin
            case (state)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    alu_op    = 3'b100;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE: begin
                    alu_src_b = 2'b11;
                    alu_op    = 3'b100;
                end
                EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = 3'b111;
                end
                EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    case (opcode)
                        OP_ORI:  alu_op = 3'b101;
                        OP_ANDI: alu_op = 3'b011;
                        default: alu_op = 3'b100;
                    endcase
                end
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = (opcode == OP_LW) ? 3'b010 : 3'b110;
                end
                MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                MEM_WRITE: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                WB_ALU: begin
                    reg_write = 1'b1;
                    reg_dst   = 2'b01;
                end
                WB_I: reg_write = 1'b1;
                WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'b01;
                end
                BRANCH: begin
                    pc_src   = 2'b01;
                    pc_write = regs_equal ^ (opcode == OP_BNE);
                end
                JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = 2'b10;
                    if (opcode == OP_JAL) begin
                        reg_write  = 1'b1;
                        reg_dst    = 2'b10;
                        mem_to_reg = 2'b10;
                    end
                end
                JR: begin
                    pc_write = 1'b1;
                    pc_src   = 2'b11;
                end
                default: ;
            endcase
        end
    end

    assign state_o = reset ? state : FETCH;
    assign illegal = reset & illegal_q;

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] instr_q;
    logic             retire;

    // An instruction retires on the cycle its final state hands control back to FETCH.
    always_comb begin
        retire = 1'b0;
        if (next_state == FETCH) begin
            case (state)
                WB_ALU, WB_I, WB_MEM, MEM_WRITE, BRANCH, JUMP, JR: retire = 1'b1;
                default: retire = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else if (state != HALT) begin
            cycle_q <= cycle_q + CNT_W'(1);
            if (retire)
                instr_q <= instr_q + CNT_W'(1);
        end
    end

    assign cycle_cnt = reset ? cycle_q : '0;
    assign instr_cnt = reset ? instr_q : '0;
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: per-cycle expected control words are queued and
// compared at the falling edge; counters are checked against CTRL_PERF_CNT_EN expectations.
module tb_multicycle_control_fsm;

    localparam int CNT_W = 4;

    localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1,  S_EXEC_R = 4'd2,  S_EXEC_I = 4'd3;
    localparam logic [3:0] S_MADDR = 4'd4,  S_MREAD = 4'd5,   S_MWRITE = 4'd6,  S_WB_ALU = 4'd7;
    localparam logic [3:0] S_WB_I = 4'd8,   S_WB_MEM = 4'd9,  S_BRANCH = 4'd10, S_JUMP = 4'd11;
    localparam logic [3:0] S_JR = 4'd12,    S_HALT = 4'd13;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic [1:0] pcs;
        logic       irw;
        logic       iord;
        logic       mr;
        logic       mw;
        logic       rw;
        logic [1:0] rdst;
        logic [1:0] m2r;
        logic       asa;
        logic [1:0] asb;
        logic [2:0] aop;
        logic       ill;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [5:0]       opcode = 6'd0;
    logic [5:0]       funct = 6'd0;
    logic             regs_equal = 1'b0;
    logic             mem_ready = 1'b1;
    logic             pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, alu_src_a, illegal;
    logic [1:0]       pc_src, reg_dst, mem_to_reg, alu_src_b;
    logic [2:0]       alu_op;
    logic [3:0]       state_o;
    logic [CNT_W-1:0] cycle_cnt, instr_cnt;
    exp_t             observed;

    int checks = 0;
    int errors = 0;
    exp_t  expQ[$];
    string tagQ[$];

    multicycle_control_fsm #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .regs_equal(regs_equal), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal(illegal), .state_o(state_o),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    assign observed = {state_o, pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write,
                       reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal};

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, got, want);
        end
    endtask

    function automatic exp_t base(input logic [3:0] st);
        exp_t e;
        e = '0;
        e.st = st;
        return e;
    endfunction

    function automatic exp_t expFetch(input logic rdy);
        exp_t e = base(S_FETCH);
        e.mr = 1'b1; e.asb = 2'b01; e.aop = 3'b100; e.pcw = rdy; e.irw = rdy;
        return e;
    endfunction

    function automatic exp_t expDecode();
        exp_t e = base(S_DECODE);
        e.asb = 2'b11; e.aop = 3'b100;
        return e;
    endfunction

    function automatic exp_t expAlu(input logic [3:0] st, input logic [1:0] srcb, input logic [2:0] aop);
        exp_t e = base(st);
        e.asa = 1'b1; e.asb = srcb; e.aop = aop;
        return e;
    endfunction

    function automatic exp_t expWb(input logic [3:0] st, input logic [1:0] rdst, input logic [1:0] m2r);
        exp_t e = base(st);
        e.rw = 1'b1; e.rdst = rdst; e.m2r = m2r;
        return e;
    endfunction

    function automatic exp_t expMem(input logic wr);
        exp_t e = base(wr ? S_MWRITE : S_MREAD);
        e.iord = 1'b1; e.mr = ~wr; e.mw = wr;
        return e;
    endfunction

    function automatic exp_t expPc(input logic [3:0] st, input logic pcw, input logic [1:0] pcs);
        exp_t e = base(st);
        e.pcw = pcw; e.pcs = pcs;
        return e;
    endfunction

    // One clock: drive inputs, queue the expectation, compare at the falling edge, then step.
    task automatic applyStimulus(input string tag, input logic rdy, input logic req, input exp_t e);
        mem_ready  = rdy;
        regs_equal = req;
        expQ.push_back(e);
        tagQ.push_back(tag);
        @(negedge clk);
        checkOutput(tagQ.pop_front(), {9'd0, observed}, {9'd0, expQ.pop_front()});
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset(input int n);
        reset = 1'b0;
        repeat (n) applyStimulus("reset", 1'b1, 1'b0, '0);
        reset = 1'b1;
    endtask

    task automatic runRtype();
        opcode = 6'b000000; funct = 6'b100000;
        applyStimulus("r_fetch", 1'b1, 1'b0, expFetch(1'b1));
        applyStimulus("r_decode", 1'b0, 1'b0, expDecode());
        applyStimulus("r_exec", 1'b1, 1'b0, expAlu(S_EXEC_R, 2'b00, 3'b111));
        applyStimulus("r_wb", 1'b0, 1'b0, expWb(S_WB_ALU, 2'b01, 2'b00));
    endtask

    task automatic runItype(input logic [5:0] op, input logic [2:0] aop);
        opcode = op; funct = 6'b001000;
        applyStimulus("i_fetch", 1'b1, 1'b0, expFetch(1'b1));
        applyStimulus("i_decode", 1'b1, 1'b0, expDecode());
        applyStimulus("i_exec", 1'b0, 1'b0, expAlu(S_EXEC_I, 2'b10, aop));
        applyStimulus("i_wb", 1'b1, 1'b0, expWb(S_WB_I, 2'b00, 2'b00));
    endtask

    task automatic runLw(input int waits);
        opcode = 6'b100011;
        applyStimulus("lw_fetch", 1'b1, 1'b0, expFetch(1'b1));
        applyStimulus("lw_decode", 1'b0, 1'b0, expDecode());
        applyStimulus("lw_addr", 1'b1, 1'b0, expAlu(S_MADDR, 2'b10, 3'b010));
        repeat (waits) applyStimulus("lw_wait", 1'b0, 1'b0, expMem(1'b0));
        applyStimulus("lw_read", 1'b1, 1'b0, expMem(1'b0));
        applyStimulus("lw_wb", 1'b1, 1'b0, expWb(S_WB_MEM, 2'b00, 2'b01));
    endtask

    task automatic runSw(input int fetchWaits, input int waits);
        opcode = 6'b101011;
        repeat (fetchWaits) applyStimulus("sw_fetch_wait", 1'b0, 1'b0, expFetch(1'b0));
        applyStimulus("sw_fetch", 1'b1, 1'b0, expFetch(1'b1));
        applyStimulus("sw_decode", 1'b1, 1'b0, expDecode());
        applyStimulus("sw_addr", 1'b1, 1'b0, expAlu(S_MADDR, 2'b10, 3'b110));
        repeat (waits) applyStimulus("sw_wait", 1'b0, 1'b0, expMem(1'b1));
        applyStimulus("sw_write", 1'b1, 1'b0, expMem(1'b1));
    endtask

    task automatic runBranch(input logic [5:0] op, input logic req, input logic pcw);
        opcode = op;
        applyStimulus("br_fetch", 1'b1, req, expFetch(1'b1));
        applyStimulus("br_decode", 1'b1, req, expDecode());
        applyStimulus("br_exec", 1'b1, req, expPc(S_BRANCH, pcw, 2'b01));
    endtask

    task automatic runJump(input logic jal);
        exp_t e;
        opcode = jal ? 6'b000011 : 6'b000010;
        e = expPc(S_JUMP, 1'b1, 2'b10);
        if (jal) begin
            e.rw = 1'b1; e.rdst = 2'b10; e.m2r = 2'b10;
        end
        applyStimulus("j_fetch", 1'b1, 1'b0, expFetch(1'b1));
        applyStimulus("j_decode", 1'b1, 1'b0, expDecode());
        applyStimulus("j_exec", 1'b1, 1'b0, e);
    endtask

    task automatic runJr();
        opcode = 6'b000000; funct = 6'b001000;
        applyStimulus("jr_fetch", 1'b1, 1'b0, expFetch(1'b1));
        applyStimulus("jr_decode", 1'b1, 1'b0, expDecode());
        applyStimulus("jr_exec", 1'b1, 1'b0, expPc(S_JR, 1'b1, 2'b11));
    endtask

    initial begin
        exp_t h;
        applyReset(2);
        runRtype();
        runLw(2);
        runSw(1, 1);
        runItype(6'b001000, 3'b100);
        runItype(6'b001101, 3'b101);
        runItype(6'b001100, 3'b011);
        runBranch(6'b000100, 1'b1, 1'b1);
        runBranch(6'b000101, 1'b1, 1'b0);
        runBranch(6'b000100, 1'b0, 1'b0);
        runBranch(6'b000101, 1'b0, 1'b1);
        runJump(1'b1);
        runJump(1'b0);
        runJr();

        // Illegal opcode parks the controller until reset.
        opcode = 6'b111111;
        applyStimulus("halt_fetch", 1'b1, 1'b0, expFetch(1'b1));
        applyStimulus("halt_decode", 1'b1, 1'b0, expDecode());
        h = base(S_HALT);
        h.ill = 1'b1;
        repeat (10) applyStimulus("halt", 1'b1, 1'b1, h);
        applyReset(1);
        runRtype();

        // Reset in the middle of a store wait aborts it.
        opcode = 6'b101011;
        applyStimulus("abort_fetch", 1'b1, 1'b0, expFetch(1'b1));
        applyStimulus("abort_decode", 1'b1, 1'b0, expDecode());
        applyStimulus("abort_addr", 1'b1, 1'b0, expAlu(S_MADDR, 2'b10, 3'b110));
        applyStimulus("abort_wait", 1'b0, 1'b0, expMem(1'b1));
        applyReset(1);
        runRtype();

        applyReset(2);
        repeat (5) runItype(6'b001000, 3'b100);
`ifdef CTRL_PERF_CNT_EN
        checkOutput("instr_cnt", {28'd0, instr_cnt}, 32'd5);
        checkOutput("cycle_cnt", {28'd0, cycle_cnt}, 32'd4);
`else
        checkOutput("instr_cnt", {28'd0, instr_cnt}, 32'd0);
        checkOutput("cycle_cnt", {28'd0, cycle_cnt}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
